// File: rtl/pool_phase_sched.sv
// Five-phase pooling scheduler: walks P1..P5 once per frame for a latched frame count,
// with hold (stall) and abort, all outputs registered.
module pool_phase_sched #(
    parameter int unsigned T1 = 33,
    parameter int unsigned T2 = 30,
    parameter int unsigned T3 = 1,
    parameter int unsigned T4 = 32,
    parameter int unsigned T5 = 990
) (
    input  logic       S_AXIS_ACLK,
    input  logic       S_AXIS_ARESETN,
    input  logic       start,
    input  logic [7:0] frames,
    input  logic       hold,
    input  logic       abort,
    output logic [4:0] phase_en,
    output logic [2:0] phase,
    output logic [7:0] frame_idx,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StP1   = 3'd1,
        StP2   = 3'd2,
        StP3   = 3'd3,
        StP4   = 3'd4,
        StP5   = 3'd5,
        StDone = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [7:0]  fidx_q, fidx_d;
    logic [7:0]  frames_q, frames_d;
    logic [4:0]  phase_en_q, phase_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic [12:0] last_cnt;
    logic        more_frames;

    always_comb begin
        last_cnt = 13'd0;
        case (state_q)
            StP1:    last_cnt = 13'(T1 - 1);
            StP2:    last_cnt = 13'(T2 - 1);
            StP3:    last_cnt = 13'(T3 - 1);
            StP4:    last_cnt = 13'(T4 - 1);
            StP5:    last_cnt = 13'(T5 - 1);
            default: last_cnt = 13'd0;
        endcase
    end

    // Widened so frame_idx + 1 cannot wrap at 255.
    assign more_frames = ({1'b0, fidx_q} + 9'd1) < {1'b0, frames_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fidx_d    = fidx_q;
        frames_d  = frames_q;
        aborted_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && (frames != 8'd0)) begin
                    state_d  = StP1;
                    cnt_d    = 13'd0;
                    fidx_d   = 8'd0;
                    frames_d = frames;
                end
            end
            StP1, StP2, StP3, StP4, StP5: begin
                if (abort) begin
                    state_d   = StIdle;
                    cnt_d     = 13'd0;
                    fidx_d    = 8'd0;
                    aborted_d = 1'b1;
                end else if (!hold) begin
                    if (cnt_q == last_cnt) begin
                        cnt_d = 13'd0;
                        if (state_q != StP5) begin
                            state_d = state_e'(state_q + 3'd1);
                        end else if (more_frames) begin
                            state_d = StP1;
                            fidx_d  = fidx_q + 8'd1;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                fidx_d  = 8'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        phase_en_d = 5'd0;
        if (!hold) begin
            case (state_d)
                StP1:    phase_en_d = 5'b00001;
                StP2:    phase_en_d = 5'b00010;
                StP3:    phase_en_d = 5'b00100;
                StP4:    phase_en_d = 5'b01000;
                StP5:    phase_en_d = 5'b10000;
                default: phase_en_d = 5'd0;
            endcase
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state_q    <= StIdle;
            cnt_q      <= 13'd0;
            fidx_q     <= 8'd0;
            frames_q   <= 8'd0;
            phase_en_q <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fidx_q     <= fidx_d;
            frames_q   <= frames_d;
            phase_en_q <= phase_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign phase_en  = phase_en_q;
    assign phase     = state_q;
    assign frame_idx = fidx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_pool_phase_sched.sv
// Scoreboard bench for pool_phase_sched: expected phase-change events are queued ahead of
// stimulus and a negedge monitor pops and compares each one the DUT presents.
module tb_pool_phase_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] frames;
    logic       hold;
    logic       abort;
    logic [4:0] phase_en;
    logic [2:0] phase;
    logic [7:0] frame_idx;
    logic       busy;
    logic       done;
    logic       aborted;

    pool_phase_sched dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESETN(rstn),
        .start         (start),
        .frames        (frames),
        .hold          (hold),
        .abort         (abort),
        .phase_en      (phase_en),
        .phase         (phase),
        .frame_idx     (frame_idx),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] ph;
        logic [7:0] fi;
        logic       dn;
        logic       ab;
    } ev_t;

    ev_t        evq[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         base = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_phase = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [2:0] ph, input logic [7:0] fi,
                           input logic dn, input logic ab);
        ev_t e;
        e.cyc = c; e.ph = ph; e.fi = fi; e.dn = dn; e.ab = ab;
        evq.push_back(e);
    endtask

    // One frame starting at cycle c0 with default phase lengths 33/30/1/32/990.
    task automatic push_frame(input int c0, input logic [7:0] fi);
        push_ev(c0,       3'd1, fi, 1'b0, 1'b0);
        push_ev(c0 + 33,  3'd2, fi, 1'b0, 1'b0);
        push_ev(c0 + 63,  3'd3, fi, 1'b0, 1'b0);
        push_ev(c0 + 64,  3'd4, fi, 1'b0, 1'b0);
        push_ev(c0 + 96,  3'd5, fi, 1'b0, 1'b0);
    endtask

    task automatic push_run(input int c0, input int n);
        for (int f = 0; f < n; f++) push_frame(c0 + f * 1086, 8'(f));
        push_ev(c0 + n * 1086,     3'd6, 8'd0, 1'b1, 1'b0);
        push_ev(c0 + n * 1086 + 1, 3'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base + 1);
        end
    endtask

    // Returns inside relative cycle k; inputs driven now are sampled at relative edge k.
    task automatic goto_edge(input int k);
        while (cyc < base + k - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic new_test();
        base = cyc + 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if ((phase !== prev_phase) || (done === 1'b1) || (aborted === 1'b1)) begin
                int   n;
                ev_t  e;
                logic [4:0] pe;
                logic       ok;
                n = cyc - base + 1;
                total++;
                if (evq.size() == 0) begin
                    bad++;
                    $display("FAIL event: unexpected at cycle %0d phase=%0d done=%0b aborted=%0b",
                             n, phase, done, aborted);
                end else begin
                    e  = evq.pop_front();
                    pe = (e.ph >= 3'd1 && e.ph <= 3'd5) ? 5'(5'd1 << (e.ph - 3'd1)) : 5'd0;
                    ok = (n == e.cyc) && (phase === e.ph) && (done === e.dn)
                         && (aborted === e.ab) && (busy === (e.ph != 3'd0)) && (phase_en === pe);
                    if (e.ph >= 3'd1 && e.ph <= 3'd5) ok = ok && (frame_idx === e.fi);
                    if (!ok) begin
                        bad++;
                        $display({"FAIL event: got cyc=%0d ph=%0d fi=%0d dn=%0b ab=%0b busy=%0b ",
                                  "en=%b expected cyc=%0d ph=%0d fi=%0d dn=%0b ab=%0b en=%b"},
                                 n, phase, frame_idx, done, aborted, busy, phase_en,
                                 e.cyc, e.ph, e.fi, e.dn, e.ab, pe);
                    end
                end
            end
            prev_phase = phase;
        end
    end

    initial begin
        rstn = 1'b0; start = 1'b0; frames = 8'd0; hold = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_phase_en", 32'(phase_en), 32'd0);
        chk("rst_frame_idx", 32'(frame_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);

        // Single frame; start on first edge out of reset; start while busy ignored.
        new_test();
        push_run(1, 1);
        mon_en = 1'b1;
        rstn = 1'b1; start = 1'b1; frames = 8'd1;
        goto_edge(1);   start = 1'b0;
        goto_edge(200); start = 1'b1; frames = 8'd5;
        goto_edge(201); start = 1'b0;
        goto_edge(1090);
        chk("single_drained", 32'(evq.size()), 32'd0);

        // Three frames.
        new_test();
        push_run(1, 3);
        start = 1'b1; frames = 8'd3;
        goto_edge(1); start = 1'b0;
        goto_edge(3262);
        chk("multi_drained", 32'(evq.size()), 32'd0);

        // Hold for 10 cycles in P2, then hold during DONE (ignored).
        new_test();
        push_ev(1, 3'd1, 8'd0, 1'b0, 1'b0);
        push_ev(34, 3'd2, 8'd0, 1'b0, 1'b0);
        push_ev(74, 3'd3, 8'd0, 1'b0, 1'b0);
        push_ev(75, 3'd4, 8'd0, 1'b0, 1'b0);
        push_ev(107, 3'd5, 8'd0, 1'b0, 1'b0);
        push_ev(1097, 3'd6, 8'd0, 1'b1, 1'b0);
        push_ev(1098, 3'd0, 8'd0, 1'b0, 1'b0);
        start = 1'b1; frames = 8'd1;
        goto_edge(1); start = 1'b0;
        goto_edge(40);
        chk("pre_hold_en", 32'(phase_en), 32'b00010);
        hold = 1'b1;
        for (int k = 41; k <= 50; k++) begin
            goto_edge(k);
            if (k == 50) hold = 1'b0;
            chk("hold_en", 32'(phase_en), 32'd0);
            chk("hold_phase", 32'(phase), 32'd2);
        end
        goto_edge(51);
        chk("post_hold_en", 32'(phase_en), 32'b00010);
        goto_edge(1097);
        chk("hold_done", 32'(done), 32'd1);
        hold = 1'b1;
        goto_edge(1098); hold = 1'b0;
        chk("done_ignores_hold", 32'(phase), 32'd0);
        goto_edge(1100);
        chk("hold_drained", 32'(evq.size()), 32'd0);

        // Abort in P5 (with hold), restart, then abort during DONE (no effect).
        new_test();
        push_frame(1, 8'd0);
        push_ev(501, 3'd0, 8'd0, 1'b0, 1'b1);
        push_run(511, 1);
        start = 1'b1; frames = 8'd1;
        goto_edge(1);   start = 1'b0;
        goto_edge(500); abort = 1'b1; hold = 1'b1;
        goto_edge(501); abort = 1'b0; hold = 1'b0;
        chk("abort_pulse", 32'(aborted), 32'd1);
        goto_edge(502);
        chk("abort_one_cycle", 32'(aborted), 32'd0);
        goto_edge(510); start = 1'b1;
        goto_edge(511); start = 1'b0;
        goto_edge(1597);
        chk("restart_done", 32'(done), 32'd1);
        abort = 1'b1;
        goto_edge(1598); abort = 1'b0;
        chk("done_ignores_abort", 32'(aborted), 32'd0);
        goto_edge(1600);
        chk("abort_drained", 32'(evq.size()), 32'd0);

        // frames=0 start is a no-op; start+abort in IDLE starts a run.
        new_test();
        start = 1'b1; frames = 8'd0;
        goto_edge(1); start = 1'b0;
        goto_edge(12);
        chk("zero_frames_busy", 32'(busy), 32'd0);
        chk("zero_frames_phase", 32'(phase), 32'd0);
        push_run(21, 1);
        goto_edge(20); start = 1'b1; abort = 1'b1; frames = 8'd1;
        goto_edge(21); start = 1'b0; abort = 1'b0;
        goto_edge(1110);
        chk("idle_abort_drained", 32'(evq.size()), 32'd0);

        // Reset mid-run overrides abort/hold/start.
        new_test();
        push_ev(1, 3'd1, 8'd0, 1'b0, 1'b0);
        push_ev(34, 3'd2, 8'd0, 1'b0, 1'b0);
        push_ev(64, 3'd3, 8'd0, 1'b0, 1'b0);
        push_ev(65, 3'd4, 8'd0, 1'b0, 1'b0);
        push_ev(71, 3'd0, 8'd0, 1'b0, 1'b0);
        start = 1'b1; frames = 8'd2;
        goto_edge(1);  start = 1'b0;
        goto_edge(70); rstn = 1'b0; abort = 1'b1; hold = 1'b1; start = 1'b1;
        goto_edge(71); rstn = 1'b1; abort = 1'b0; hold = 1'b0; start = 1'b0;
        chk("mid_rst_phase", 32'(phase), 32'd0);
        chk("mid_rst_phase_en", 32'(phase_en), 32'd0);
        chk("mid_rst_frame_idx", 32'(frame_idx), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_aborted", 32'(aborted), 32'd0);
        goto_edge(75);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        chk("rst_drained", 32'(evq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool_phase_sched.md
POOL_PHASE_SCHED -- requirements
Module: pool_phase_sched

Interface
REQ-001 Parameter T1, 33, P1 (load) phase length in cycles; range 1..8191.
REQ-002 Parameter T2, 30, P2 (compute) phase length in cycles; range 1..8191.
REQ-003 Parameter T3, 1, P3 (latch) phase length in cycles; range 1..8191.
REQ-004 Parameter T4, 32, P4 (accumulate) phase length in cycles; range 1..8191.
REQ-005 Parameter T5, 990, P5 (output drain) phase length in cycles; range 1..8191.
REQ-006 S_AXIS_ACLK  in  1  sole clock; all logic on rising edge.
REQ-007 S_AXIS_ARESETN  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  begin a run; sampled only in IDLE.
REQ-009 frames  in  8  number of frames per run; latched with start.
REQ-010 hold  in  1  stall: freezes state, phase counter and frame counter.
REQ-011 abort  in  1  terminate run; synchronous.
REQ-012 phase_en  out  5  one-hot phase enable, bit k-1 = phase Pk.
REQ-013 phase  out  3  encoded state: 0 IDLE, 1..5 P1..P5, 6 DONE.
REQ-014 frame_idx  out  8  zero-based index of current frame.
REQ-015 busy  out  1  high in P1..P5 and DONE.
REQ-016 done  out  1  one-cycle pulse, run completed normally.
REQ-017 aborted  out  1  one-cycle pulse, run terminated by abort.

Function
REQ-018 FSM states IDLE, P1, P2, P3, P4, P5, DONE; all outputs registered.
REQ-019 IDLE: start=1 and frames!=0 -> P1 next cycle, frames latched, phase counter=0, frame_idx=0.
REQ-020 IDLE: start=1 with frames=0 -> no action, stay IDLE, no pulses.
REQ-021 start while busy is ignored; latched frame count unaffected.
REQ-022 Single 13-bit phase counter, cleared on every phase entry; increments each cycle in Pk with hold=0.
REQ-023 Pk with counter==Tk-1 and hold=0 -> next phase (P1->P2->P3->P4->P5), counter to 0; each phase occupies exactly Tk non-held cycles.
REQ-024 P5 completion: frame_idx+1 < latched frames -> P1, frame_idx+1; else -> DONE.
REQ-025 DONE lasts one cycle with done=1, then IDLE; hold ignored in DONE.
REQ-026 hold=1 in P1..P5: state, phase counter, frame_idx frozen; phase_en=0; phase still shows current state.
REQ-027 phase_en = one-hot of current Pk AND NOT hold, registered; 0 in IDLE and DONE.
REQ-028 abort=1 in P1..P5 (regardless of hold) -> IDLE next cycle, aborted=1 that cycle, no done.
REQ-029 abort in IDLE or DONE: no effect; DONE still completes with done=1.
REQ-030 abort and start same cycle in IDLE: start honoured (abort has no effect in IDLE).
REQ-031 No counter wraps: phase counter bounded by Tk-1, frame_idx bounded by frames-1 (max 254).

Reset
REQ-032 S_AXIS_ARESETN=0 at a rising edge: state IDLE, phase counter 0, frame_idx 0, latched frames 0, phase_en 0, phase 0, busy 0, done 0, aborted 0.
REQ-033 Reset mid-run overrides abort/hold/start; no done or aborted pulse generated.
REQ-034 First start honoured on the first edge with S_AXIS_ARESETN=1.

Verification
REQ-035 Defaults, frames=1, start at edge 0, hold=0 -> phase_en[0] cycles 1-33, [1] 34-63, [2] 64, [3] 65-96, [4] 97-1086; done=1 only at cycle 1087; busy 0 at 1088.
REQ-036 frames=3 -> three full P1..P5 sequences, frame_idx 0,1,2, single done at cycle 3*1086+1=3259.
REQ-037 hold high 10 cycles starting cycle 40 (in P2) -> phase_en=0 during hold, phase=2, P2 ends at cycle 73, done at 1097.
REQ-038 abort at cycle 500 (P5) -> IDLE and aborted=1 at 501, no done; new start at 510 reproduces REQ-035 timing offset by 510.
REQ-039 start with frames=0 -> busy stays 0, no pulses; start while busy at cycle 200 -> timing unchanged.
REQ-040 S_AXIS_ARESETN low for 1 cycle at cycle 70 -> all outputs at reset values next cycle, no done/aborted.
